// File: rtl/lifo_stack_pkg.sv
// Shared types and helpers for the extended LIFO stack.
package lifo_stack_pkg;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_CLEAR
  } stack_op_e;

  function automatic int depth_f(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// Flop-array storage for the LIFO: one synchronous write port, one asynchronous read port, no reset.
module lifo_mem
  import lifo_stack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_f(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read keeps the top-of-stack visible in the same cycle it changes.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack_ext.sv
// LIFO stack with replace-top, FWFT top output, occupancy count, thresholds,
// synchronous clear and sticky overflow/underflow flags.
module lifo_stack_ext
  import lifo_stack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                  DEPTH    = depth_f(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH    = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_TH    = (ADDR_WIDTH+1)'(AE_MARGIN);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  stack_op_e               op;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [ADDR_WIDTH-1:0]   top_addr;
  logic [ADDR_WIDTH-1:0]   push_addr;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);

  // When full the low bits wrap to zero, so subtracting one still lands on DEPTH-1.
  assign top_addr  = count_q[ADDR_WIDTH-1:0] - ADDR_ONE;
  assign push_addr = count_q[ADDR_WIDTH-1:0];

  always_comb begin
    op = OP_IDLE;
    if (clear) begin
      op = OP_CLEAR;
    end else if (push && pop) begin
      op = OP_REPLACE;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop) begin
      op = OP_POP;
    end
  end

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = push_addr;
    case (op)
      OP_CLEAR: begin
        count_d     = '0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      OP_REPLACE: begin
        mem_we = 1'b1;
        if (empty) begin
          mem_waddr   = '0;
          count_d     = CNT_ONE;
          underflow_d = 1'b1;
        end else begin
          mem_waddr = top_addr;
        end
      end
      OP_PUSH: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_ONE;
        end
      end
      OP_POP: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  lifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wr_data),
    .raddr (top_addr),
    .rdata (mem_rdata)
  );

  assign rd_data   = empty ? '0 : mem_rdata;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_lifo_stack_ext.sv
// Directed bench for lifo_stack_ext (DEPTH=4, margins 1): hand-computed expectations per step.
module tb_lifo_stack_ext;

  logic       clk = 1'b0;
  logic       arst;
  logic       clear;
  logic       push;
  logic       pop;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [2:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lifo_stack_ext #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2),
    .AF_MARGIN  (1),
    .AE_MARGIN  (1)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .clear        (clear),
    .push         (push),
    .wr_data      (wr_data),
    .pop          (pop),
    .rd_data      (rd_data),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Flags are derived from the expected count: full at 4, empty at 0, af at >=3, ae at <=1.
  task automatic chk_all(input string tag, input int cnt, input logic [7:0] rd,
                         input logic ovf, input logic udf);
    chk(tag, "count", 32'(count), 32'(cnt));
    chk(tag, "rd_data", 32'(rd_data), 32'(rd));
    chk(tag, "full", 32'(full), 32'(cnt == 4));
    chk(tag, "empty", 32'(empty), 32'(cnt == 0));
    chk(tag, "almost_full", 32'(almost_full), 32'(cnt >= 3));
    chk(tag, "almost_empty", 32'(almost_empty), 32'(cnt <= 1));
    chk(tag, "overflow", 32'(overflow), 32'(ovf));
    chk(tag, "underflow", 32'(underflow), 32'(udf));
    $display("[TB] %s: count=%0d rd_data=%02h ovf=%0b udf=%0b", tag, count, rd_data, overflow, underflow);
  endtask

  task automatic step(input logic p, input logic po, input logic c, input logic [7:0] d);
    push = p; pop = po; clear = c; wr_data = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; wr_data = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; wr_data = 8'h00;
    #22;
    arst = 1'b0;
    chk_all("reset", 0, 8'h00, 1'b0, 1'b0);

    // Fill, then overflow
    step(1, 0, 0, 8'h11); chk_all("push11", 1, 8'h11, 0, 0);
    step(1, 0, 0, 8'h22); chk_all("push22", 2, 8'h22, 0, 0);
    step(1, 0, 0, 8'h33); chk_all("push33", 3, 8'h33, 0, 0);
    step(1, 0, 0, 8'h44); chk_all("push44", 4, 8'h44, 0, 0);
    step(1, 0, 0, 8'h55); chk_all("push55_ovf", 4, 8'h44, 1, 0);

    // Drain, then underflow
    step(0, 1, 0, 8'h00); chk_all("pop1", 3, 8'h33, 1, 0);
    step(0, 1, 0, 8'h00); chk_all("pop2", 2, 8'h22, 1, 0);
    step(0, 1, 0, 8'h00); chk_all("pop3", 1, 8'h11, 1, 0);
    step(0, 1, 0, 8'h00); chk_all("pop4", 0, 8'h00, 1, 0);
    step(0, 1, 0, 8'h00); chk_all("pop5_udf", 0, 8'h00, 1, 1);

    // Replace-top, including at full
    step(0, 0, 1, 8'h00); chk_all("clear1", 0, 8'h00, 0, 0);
    step(1, 0, 0, 8'hA0); chk_all("pushA0", 1, 8'hA0, 0, 0);
    step(1, 1, 0, 8'hB0); chk_all("replB0", 1, 8'hB0, 0, 0);
    step(1, 0, 0, 8'h01); chk_all("push01", 2, 8'h01, 0, 0);
    step(1, 0, 0, 8'h02); chk_all("push02", 3, 8'h02, 0, 0);
    step(1, 0, 0, 8'h03); chk_all("push03", 4, 8'h03, 0, 0);
    step(1, 1, 0, 8'hCC); chk_all("replCC_full", 4, 8'hCC, 0, 0);
    step(0, 1, 0, 8'h00); chk_all("pop_after_repl", 3, 8'h02, 0, 0);

    // Push+pop on empty
    step(0, 0, 1, 8'h00); chk_all("clear2", 0, 8'h00, 0, 0);
    step(1, 1, 0, 8'h5A); chk_all("repl5A_empty", 1, 8'h5A, 0, 1);

    // Build count=3 with both flags set, then clear with push
    step(1, 0, 0, 8'h66); chk_all("push66", 2, 8'h66, 0, 1);
    step(1, 0, 0, 8'h67); chk_all("push67", 3, 8'h67, 0, 1);
    step(1, 0, 0, 8'h68); chk_all("push68", 4, 8'h68, 0, 1);
    step(1, 0, 0, 8'h69); chk_all("push69_ovf", 4, 8'h68, 1, 1);
    step(0, 1, 0, 8'h00); chk_all("pop_to3", 3, 8'h67, 1, 1);
    step(1, 0, 1, 8'h99); chk_all("clear_push", 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'h00); chk_all("pop_after_clear", 0, 8'h00, 0, 1);

    // Asynchronous reset between edges
    step(0, 0, 1, 8'h00); chk_all("clear3", 0, 8'h00, 0, 0);
    step(1, 0, 0, 8'h31); chk_all("push31", 1, 8'h31, 0, 0);
    step(1, 0, 0, 8'h32); chk_all("push32", 2, 8'h32, 0, 0);
    #2;
    arst = 1'b1;
    #1;
    chk_all("arst_mid", 0, 8'h00, 0, 0);
    arst = 1'b0;
    #2;
    step(1, 0, 0, 8'h77); chk_all("push77", 1, 8'h77, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lifo_stack_ext.md
Name: lifo_stack_ext

Overview:
Parametrised LIFO stack, the next generation of the team's basic stack. Adds simultaneous push+pop (replace-top), first-word-fall-through top-of-stack output, an occupancy count, almost-full/almost-empty thresholds, a synchronous clear, and sticky overflow/underflow error flags. It sits between a producer and a consumer that share one clock domain, for example as an expression-evaluation or return-address stack in datapath examples.

Parameters:
DATA_WIDTH, 32, width of each stack entry
ADDR_WIDTH, 4, entry address width; DEPTH = 2**ADDR_WIDTH entries
AF_MARGIN, 1, almost_full asserts when count >= DEPTH-AF_MARGIN; legal range 0..DEPTH-1
AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN; legal range 0..DEPTH-1

Ports:
clk  in  1  rising-edge clock
arst  in  1  asynchronous active-high reset
clear  in  1  synchronous flush: empties the stack and clears the error flags
push  in  1  write request
wr_data  in  DATA_WIDTH  data to push
pop  in  1  remove-top request
rd_data  out  DATA_WIDTH  current top of stack (FWFT); 0 when empty
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= DEPTH-AF_MARGIN
almost_empty  out  1  count <= AE_MARGIN
overflow  out  1  sticky flag: a push was dropped
underflow  out  1  sticky flag: a pop occurred while empty

Behaviour:
- Reset (arst=1, asynchronous): count=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_empty=1, almost_full=(AF_MARGIN>=DEPTH ? 1 : 0), rd_data=0. Memory contents are not reset.
- Reset deasserted mid-operation: any in-flight request is discarded. The first post-reset edge with requests is processed normally.
- State is count (ADDR_WIDTH+1 bits) plus the memory. The top entry is mem[count-1], and writes go to mem[count].
- rd_data is combinational from mem[count-1], gated to 0 when empty. After any edge that changes the stack, rd_data reflects the new top in the same cycle (zero read latency).
- All flags are combinational decodes of count, except overflow and underflow, which are registered sticky bits.
- Per-edge priority, highest first:
  1. clear=1: count<=0, overflow<=0, underflow<=0. push and pop are ignored and no error is flagged.
  2. push & pop, not empty: replace-top. mem[count-1]<=wr_data, count unchanged. This is legal when full; no overflow.
  3. push & pop, empty: mem[0]<=wr_data, count<=1, underflow<=1.
  4. push only, not full: mem[count]<=wr_data, count<=count+1.
  5. push only, full: write dropped, count unchanged, overflow<=1.
  6. pop only, not empty: count<=count-1.
  7. pop only, empty: no change, underflow<=1.
  8. idle: no change.
- Sticky flags hold until clear or arst. No wrap-around: count saturates at 0 and DEPTH by rule.
- Memory write enable = (push & ~clear) & (~full | pop). Write address = (pop & ~empty) ? count-1 : count.
- The design is fully synchronous apart from arst, has no combinational path from inputs to outputs, and contains no latches.

Decomposition:
- Package lifo_stack_pkg holds the stack_op_e enum (OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE, OP_CLEAR) and the localparam-computing function depth_f(addr_width).
- One sub-module, lifo_mem: a flop array with one write port and one asynchronous read port, parameterised by DATA_WIDTH and ADDR_WIDTH, with no reset.
- The top level contains the op decode, count register, flag logic and read gating.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AF_MARGIN=1, AE_MARGIN=1):
1. Reset, then push 0x11,0x22,0x33,0x44 -> rd_data 0x11,0x22,0x33,0x44 after successive edges; count=4, full=1, almost_full from count=3. A fifth push of 0x55 -> overflow=1, count=4, rd_data=0x44.
2. From full, pop x4 -> rd_data 0x33,0x22,0x11,0 (empty=1); almost_empty at count<=1. A fifth pop -> underflow=1, count=0.
3. Push 0xA0 then push+pop 0xB0 -> count=1, rd_data=0xB0. At full, push+pop 0xCC -> count=4, top=0xCC, overflow stays 0.
4. Empty, push+pop 0x5A -> count=1, rd_data=0x5A, underflow=1.
5. With count=3 and both error flags set, clear together with push -> count=0, flags=0, and no write visible on a later pop.
6. arst pulsed asynchronously between edges while count=2 -> count=0 and empty=1 immediately, before the next edge. The next push of 0x77 -> rd_data=0x77.
